// File: rtl/wide_add_arbiter_seq.sv
// Round-robin shares one SLICE_W adder between two requesters for TOTAL_W sums; rsp_valid NUM_SLICES edges after accept.
// Ready only in IDLE for the granted requester; result held until rsp_ready. WIDE_ADD_SUB_EN adds per-request subtract.
module wide_add_arbiter_seq #(
   parameter int TOTAL_W = 1024,
   parameter int SLICE_W = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [TOTAL_W-1:0] req0_a,
   input  logic [TOTAL_W-1:0] req0_b,
`ifdef WIDE_ADD_SUB_EN
   input  logic               req0_sub,
   input  logic               req1_sub,
`endif
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [TOTAL_W-1:0] req1_a,
   input  logic [TOTAL_W-1:0] req1_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [TOTAL_W-1:0] rsp_sum,
   output logic               rsp_carry,
   output logic               rsp_id,
   output logic               busy
);
   localparam int NUM_SLICES = TOTAL_W / SLICE_W;
   localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [TOTAL_W-1:0] a_q, b_q;
   logic [CNT_W-1:0]   cnt;
   logic               carry, last_grant, sub_q;
   logic               grant0, grant1, accept, accept_id, accept_sub;
   logic [SLICE_W-1:0] b_slice;
   logic [SLICE_W:0]   slice_sum;

   // Contention goes to whoever was not served last.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
   end

   assign req0_ready = (state == IDLE) && grant0;
   assign req1_ready = (state == IDLE) && grant1;
   assign accept     = req0_ready || req1_ready;
   assign accept_id  = req1_ready;

`ifdef WIDE_ADD_SUB_EN
   assign accept_sub = req1_ready ? req1_sub : req0_sub;
`else
   assign accept_sub = 1'b0;
`endif

   // Operands shift right each RUN cycle so slice 0 is always the live one.
   assign b_slice   = b_q[SLICE_W-1:0] ^ {SLICE_W{sub_q}};
   assign slice_sum = {1'b0, a_q[SLICE_W-1:0]} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST_CNT) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         sub_q      <= 1'b0;
         last_grant <= 1'b1;
         rsp_sum    <= '0;
         rsp_carry  <= 1'b0;
         rsp_id     <= 1'b0;
      end else if (accept) begin
         a_q        <= req1_ready ? req1_a : req0_a;
         b_q        <= req1_ready ? req1_b : req0_b;
         rsp_id     <= accept_id;
         last_grant <= accept_id;
         cnt        <= '0;
         carry      <= accept_sub;
         sub_q      <= accept_sub;
      end else if (state == RUN) begin
         a_q     <= a_q >> SLICE_W;
         b_q     <= b_q >> SLICE_W;
         // Result fills from the top; after NUM_SLICES shifts slice 0 lands at the LSBs.
         rsp_sum <= (rsp_sum >> SLICE_W) | (TOTAL_W'(slice_sum[SLICE_W-1:0]) << (TOTAL_W - SLICE_W));
         carry   <= slice_sum[SLICE_W];
         cnt     <= cnt + CNT_W'(1);
         if (cnt == LAST_CNT) rsp_carry <= slice_sum[SLICE_W];
      end
   end

endmodule

// File: tb/tb_wide_add_arbiter_seq.sv
// Bench for wide_add_arbiter_seq: queued request drivers, arithmetic reference model, scoreboard monitor on the falling edge.
module tb_wide_add_arbiter_seq;
   localparam int W  = 1024;
   localparam int SW = 64;
   localparam int NS = W / SW;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
`ifdef WIDE_ADD_SUB_EN
   logic         req0_sub = 1'b0, req1_sub = 1'b0;
`endif
   logic         rsp_valid, rsp_carry, rsp_id, busy;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_sum;

   always #5 clk = ~clk;

   wide_add_arbiter_seq #(.TOTAL_W(W), .SLICE_W(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
`ifdef WIDE_ADD_SUB_EN
      .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
      .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy)
   );

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic sub; } job_t;
   typedef struct { logic [W-1:0] sum; logic carry; logic id; } exp_t;

   job_t         job_q0[$];
   job_t         job_q1[$];
   exp_t         exp_q[$];
   logic         id_log[$];
   int           checks = 0, errors = 0;
   logic         pending = 1'b0, last_id = 1'b1, rst_prev = 1'b1;
   int           lat = 0;
   logic         rand_rdy = 1'b0, fixed_rdy = 1'b1;
   logic [W-1:0] last_sum = '0;
   logic         last_carry = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      int k;
      checks++;
      if (act !== exp) begin
         errors++;
         k = 0;
         for (int i = NS - 1; i >= 0; i--) if (act[i*SW +: SW] !== exp[i*SW +: SW]) k = i;
         $display("FAIL %s: slice %0d got %h want %h at %0t", name, k, act[k*SW +: SW], exp[k*SW +: SW], $time);
      end
   endtask

   // Reference: plain wide arithmetic; carry on subtract means no borrow.
   function automatic exp_t model(input job_t j, input logic id);
      exp_t         e;
      logic [W:0]   t;
      if (j.sub) begin
         e.sum   = j.a - j.b;
         e.carry = (j.a >= j.b);
      end else begin
         t       = {1'b0, j.a} + {1'b0, j.b};
         e.sum   = t[W-1:0];
         e.carry = t[W];
      end
      e.id = id;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_wide();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = '1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      job_t j;
      j.a = a; j.b = b; j.sub = sub;
      if (id == 0) job_q0.push_back(j);
      else job_q1.push_back(j);
   endtask

   task automatic drain();
      int n = 0;
      while ((job_q0.size() != 0 || job_q1.size() != 0 || pending) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL drain_timeout: waited %0d cycles, want all jobs completed", n);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Requester 0 driver: presents the head job until it sees ready on a falling edge.
   initial begin : drv0
      job_t j;
      forever begin
         @(posedge clk); #2;
         if (!rst_n || job_q0.size() == 0) begin
            req0_valid = 1'b0;
         end else begin
            j = job_q0[0];
            req0_valid = 1'b1; req0_a = j.a; req0_b = j.b;
`ifdef WIDE_ADD_SUB_EN
            req0_sub = j.sub;
`endif
         end
         @(negedge clk);
         if (rst_n && req0_valid && req0_ready) j = job_q0.pop_front();
      end
   end

   initial begin : drv1
      job_t j;
      forever begin
         @(posedge clk); #2;
         if (!rst_n || job_q1.size() == 0) begin
            req1_valid = 1'b0;
         end else begin
            j = job_q1[0];
            req1_valid = 1'b1; req1_a = j.a; req1_b = j.b;
`ifdef WIDE_ADD_SUB_EN
            req1_sub = j.sub;
`endif
         end
         @(negedge clk);
         if (rst_n && req1_valid && req1_ready) j = job_q1.pop_front();
      end
   end

   initial begin : rsp_drv
      forever begin
         @(posedge clk); #2;
         rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
      end
   end

   initial begin : monitor
      job_t j;
      exp_t e;
      logic e0, e1, aid;
      forever begin
         @(negedge clk);
         if (!rst_prev) begin
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_rsp_valid", rsp_valid, 1'b0);
            chk1("rst_rsp_carry", rsp_carry, 1'b0);
            chk1("rst_rsp_id", rsp_id, 1'b0);
            chkw("rst_rsp_sum", rsp_sum, '0);
         end
         if (!rst_n) begin
            exp_q.delete();
            pending = 1'b0; lat = 0; last_id = 1'b1;
         end else begin
            if (pending) lat++;
            chk1("busy", busy, pending);
            chk1("rsp_valid", rsp_valid, pending && lat >= NS);
            e0 = !pending && req0_valid && (!req1_valid || last_id);
            e1 = !pending && req1_valid && (!req0_valid || !last_id);
            chk1("req0_ready", req0_ready, e0);
            chk1("req1_ready", req1_ready, e1);
            if (rsp_valid && exp_q.size() > 0) begin
               e = exp_q[0];
               chkw("rsp_sum", rsp_sum, e.sum);
               chk1("rsp_carry", rsp_carry, e.carry);
               chk1("rsp_id", rsp_id, e.id);
               if (rsp_ready) begin
                  e = exp_q.pop_front();
                  id_log.push_back(rsp_id);
                  last_sum = rsp_sum; last_carry = rsp_carry;
                  pending = 1'b0;
               end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
               aid = !(req0_valid && req0_ready);
               j.a = aid ? req1_a : req0_a;
               j.b = aid ? req1_b : req0_b;
`ifdef WIDE_ADD_SUB_EN
               j.sub = aid ? req1_sub : req0_sub;
`else
               j.sub = 1'b0;
`endif
               exp_q.push_back(model(j, aid));
               last_id = aid; pending = 1'b1; lat = -1;
            end
         end
         rst_prev = rst_n;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not complete, ERRORS %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic         exp_ids[4];
      logic [W-1:0] ones, three, four;
      int           n;
      ones = '1; three = W'(3); four = W'(4);
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Carry ripples through every slice.
      push(0, ones, W'(1), 1'b0);
      drain();
      chkw("ones_plus_one_sum", last_sum, '0);
      chk1("ones_plus_one_carry", last_carry, 1'b1);

      // Idle reset restores requester-0 priority, then contention alternates.
      pulse_reset();
      id_log.delete();
      push(0, three, four, 1'b0); push(1, three, four, 1'b0);
      drain();
      push(0, three, four, 1'b0); push(1, three, four, 1'b0);
      drain();
      checks++;
      if (id_log.size() != 4) begin
         errors++;
         $display("FAIL alt_count: got %0d responses want 4", id_log.size());
      end else begin
         for (int i = 0; i < 4; i++) chk1("alt_id_order", id_log[i], exp_ids[i]);
      end
      chkw("three_plus_four", last_sum, W'(7));

      // Consumer stalls in DONE while requester 1 waits.
      fixed_rdy = 1'b0;
      push(0, rnd_wide(), rnd_wide(), 1'b0);
      push(1, rnd_wide(), rnd_wide(), 1'b0);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL stall_wait: rsp_valid 0 after %0d cycles want 1", n); end
      repeat (5) @(posedge clk);
      #1 fixed_rdy = 1'b1;
      drain();

      // Reset in the middle of a job abandons it.
      push(0, rnd_wide(), rnd_wide(), 1'b0);
      n = 0;
      while (!(pending && lat == 7) && n < 100) begin @(posedge clk); n++; end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL midrun_wait: slice 7 not reached in %0d cycles", n); end
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      push(1, rnd_wide(), rnd_wide(), 1'b0);
      drain();

`ifdef WIDE_ADD_SUB_EN
      push(0, W'(5), W'(7), 1'b1);
      drain();
      chkw("sub_5_7_sum", last_sum, {{(W-1){1'b1}}, 1'b0});
      chk1("sub_5_7_carry", last_carry, 1'b0);
      push(1, W'(7), W'(5), 1'b1);
      drain();
      chkw("sub_7_5_sum", last_sum, W'(2));
      chk1("sub_7_5_carry", last_carry, 1'b1);
`endif

      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: push(0, rnd_wide(), rnd_wide(), 1'($urandom_range(0, 1)) & sub_ok());
            1: push(1, rnd_wide(), rnd_wide(), 1'($urandom_range(0, 1)) & sub_ok());
            default: begin
               push(0, rnd_wide(), rnd_wide(), 1'($urandom_range(0, 1)) & sub_ok());
               push(1, rnd_wide(), rnd_wide(), 1'($urandom_range(0, 1)) & sub_ok());
            end
         endcase
         repeat ($urandom_range(0, 30)) @(posedge clk);
      end
      drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic sub_ok();
`ifdef WIDE_ADD_SUB_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

endmodule
